// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the core sequencer: FSM state encoding and register-index constants.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    WRITE   = 3'd4,
    HALTED  = 3'd5,
    FAULT   = 3'd6
  } ctrl_state_e;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = '0;

endpackage

// File: rtl/cpu_stage_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the core datapath blocks (slave).
interface cpu_stage_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import cpu_ctrl_pkg::*;

  logic                 run;
  logic                 halt_req;
  logic                 imem_req;
  logic [XLEN-1:0]      imem_addr;
  logic                 imem_ack;
  logic                 fetch_latch;
  logic                 decode_latch;
  logic                 exec_multi;
  logic                 exec_start;
  logic                 exec_done;
  logic                 br_taken;
  logic [XLEN-1:0]      br_target;
  logic [REG_IDX_W-1:0] rd_idx;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [XLEN-1:0]      pc;
  logic [2:0]           state;
  logic [CNT_W-1:0]     retire_cnt;
  logic                 halted;
  logic                 fault;

  modport master (
    input  run, halt_req, imem_ack, exec_multi, exec_done, br_taken, br_target, rd_idx,
    output imem_req, imem_addr, fetch_latch, decode_latch, exec_start, rf_we, rf_waddr,
           pc, state, retire_cnt, halted, fault
  );

  modport slave (
    output run, halt_req, imem_ack, exec_multi, exec_done, br_taken, br_target, rd_idx,
    input  imem_req, imem_addr, fetch_latch, decode_latch, exec_start, rf_we, rf_waddr,
           pc, state, retire_cnt, halted, fault
  );

endinterface

// File: rtl/cpu_ctrl_wdog.sv
// Instruction-fetch wait counter; flags the no-ack cycle that would reach the timeout.
module cpu_ctrl_wdog #(
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int W = $clog2(IMEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Asserted on the increment that makes the count equal IMEM_TIMEOUT.
  assign expired_o = inc_i && (cnt_q == W'(IMEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITE sequencer with run/halt control and fetch watchdog.
module cpu_stage_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              PC_STEP      = 1,
  parameter int              IMEM_TIMEOUT = 15,
  parameter int              CNT_W        = 32
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cpu_stage_ctrl_if.master     bus
);

  ctrl_state_e      state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             halt_q, halt_d;
  logic             first_q, first_d;

  logic halt_now;
  logic exec_exit;
  logic wd_clr, wd_inc, wd_expired;

  assign halt_now  = halt_q || bus.halt_req;
  assign exec_exit = !bus.exec_multi || bus.exec_done;
  assign wd_clr    = (state_q == FETCH) && bus.imem_ack;
  assign wd_inc    = (state_q == FETCH) && !bus.imem_ack;

  cpu_ctrl_wdog #(.IMEM_TIMEOUT(IMEM_TIMEOUT)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wd_clr),
    .inc_i     (wd_inc),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (halt_now) state_d = HALTED;
               else if (bus.run) state_d = FETCH;
      FETCH:   if (bus.imem_ack) state_d = DECODE;
               else if (wd_expired) state_d = FAULT;
      DECODE:  state_d = EXECUTE;
      EXECUTE: if (exec_exit) state_d = WRITE;
      WRITE:   if (halt_now) state_d = HALTED;
               else if (bus.run) state_d = FETCH;
               else state_d = IDLE;
      HALTED:  state_d = HALTED;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req     = 1'b0;
    bus.fetch_latch  = 1'b0;
    bus.decode_latch = 1'b0;
    bus.exec_start   = 1'b0;
    bus.rf_we        = 1'b0;
    bus.rf_waddr     = REG_ZERO;
    unique case (state_q)
      FETCH: begin
        bus.imem_req    = 1'b1;
        bus.fetch_latch = bus.imem_ack;
      end
      DECODE:  bus.decode_latch = 1'b1;
      EXECUTE: bus.exec_start   = first_q;
      WRITE: begin
        bus.rf_waddr = bus.rd_idx;
        bus.rf_we    = (bus.rd_idx != REG_ZERO);
      end
      default: ;
    endcase
  end

  // PC, retire counter, sticky halt request and first-EXECUTE-cycle flag.
  always_comb begin
    pc_d    = pc_q;
    ret_d   = ret_q;
    halt_d  = halt_now;
    first_d = (state_q == DECODE);
    if ((state_q == EXECUTE) && exec_exit)
      pc_d = bus.br_taken ? bus.br_target : pc_q + XLEN'(PC_STEP);
    if (state_q == WRITE)
      ret_d = ret_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      ret_q   <= '0;
      halt_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      halt_q  <= halt_d;
      first_q <= first_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.state      = state_q;
  assign bus.retire_cnt = ret_q;
  assign bus.halted     = (state_q == HALTED);
  assign bus.fault      = (state_q == FAULT);

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Self-checking bench for cpu_stage_ctrl: vector table, corner sequences and random instructions.
module tb_cpu_stage_ctrl;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cpu_stage_ctrl_if #(.XLEN(32), .CNT_W(32)) bif ();

  cpu_stage_ctrl #(
    .XLEN(32), .RESET_PC(32'd0), .PC_STEP(1), .IMEM_TIMEOUT(15), .CNT_W(32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    int          reqn;
    bit          multi;
    int          exen;
    bit          br;
    logic [31:0] tgt;
    logic [4:0]  rd;
    int          exp_cyc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.run = 1'b0; bif.halt_req = 1'b0; bif.imem_ack = 1'b0;
    bif.exec_multi = 1'b0; bif.exec_done = 1'b0; bif.br_taken = 1'b0;
    bif.br_target = '0; bif.rd_idx = '0;
    step();
    chk("rst_state", bif.state, 3'd0);
    chk("rst_pc", bif.pc, 32'd0);
    chk("rst_retire", bif.retire_cnt, 32'd0);
    chk("rst_strobes", {bif.imem_req, bif.fetch_latch, bif.decode_latch, bif.exec_start, bif.rf_we}, 5'd0);
    chk("rst_flags", {bif.halted, bif.fault}, 2'd0);
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction from the current IDLE/FETCH cycle through its WRITE cycle,
  // acting as instruction memory and executer, then checks the transaction.
  task automatic do_instr(input int reqn, input bit multi, input int exen, input bit br,
                          input logic [31:0] tgt, input logic [4:0] rd, input bit halt_dec,
                          input bit run_drop, input int exp_cyc, input logic [31:0] pc0,
                          input logic [31:0] pc1, input logic [31:0] ret1, input string tag);
    int cyc = 0, nreq = 0, nfl = 0, nes = 0, nex = 0;
    bit done = 0, addr_ok = 1, we_s = 0;
    logic [4:0] wa_s = '0;
    bif.exec_multi = multi; bif.br_taken = br; bif.br_target = tgt; bif.rd_idx = rd;
    while (!done && cyc < 200) begin
      cyc++;
      bif.imem_ack  = bif.imem_req && (nreq == reqn - 1);
      bif.exec_done = (bif.state == 3'd3) && multi && (nex == exen - 1);
      bif.halt_req  = halt_dec && (bif.state == 3'd2);
      if (run_drop && bif.state == 3'd2) bif.run = 1'b0;
      #1;
      if (bif.imem_req) begin
        nreq++;
        if (bif.imem_addr !== pc0) addr_ok = 0;
      end
      if (bif.state == 3'd3) nex++;
      nfl += int'(bif.fetch_latch);
      nes += int'(bif.exec_start);
      if (bif.state == 3'd4) begin
        done = 1; we_s = bif.rf_we; wa_s = bif.rf_waddr;
      end
      @(posedge clk);
      #1;
    end
    bif.halt_req = 1'b0; bif.imem_ack = 1'b0; bif.exec_done = 1'b0;
    chk({tag, "_reached_write"}, done, 1'b1);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_req_cycles"}, nreq, reqn);
    chk({tag, "_addr_stable"}, addr_ok, 1'b1);
    chk({tag, "_fetch_latch"}, nfl, 1);
    chk({tag, "_exec_start"}, nes, 1);
    chk({tag, "_rf_we"}, we_s, (rd != 5'd0));
    chk({tag, "_rf_waddr"}, wa_s, rd);
    chk({tag, "_pc"}, bif.pc, pc1);
    chk({tag, "_retire"}, bif.retire_cnt, ret1);
  endtask

  initial begin
    logic [31:0] pc_m, pc_n, tgt;
    int          ret_m, reqn, exen, exp_cyc, n, nreq, fcyc;
    bit          multi, br, drop, from_idle;
    logic [4:0]  rd;

    tbl[0] = '{1, 0, 1, 0, 32'h0,        5'd3,  5,  32'h1};
    tbl[1] = '{4, 0, 1, 0, 32'h0,        5'd5,  7,  32'h2};
    tbl[2] = '{1, 1, 6, 1, 32'h40,       5'd7,  9,  32'h40};
    tbl[3] = '{1, 0, 1, 0, 32'h0,        5'd0,  4,  32'h41};
    tbl[4] = '{1, 1, 1, 0, 32'h0,        5'd1,  4,  32'h42};
    tbl[5] = '{2, 1, 3, 1, 32'h123,      5'd31, 7,  32'h123};
    tbl[6] = '{15, 0, 1, 0, 32'h0,       5'd2,  18, 32'h124};
    tbl[7] = '{1, 0, 1, 1, 32'hFFFFFFFF, 5'd4,  4,  32'hFFFFFFFF};
    tbl[8] = '{1, 0, 1, 0, 32'h0,        5'd4,  4,  32'h0};

    step();
    do_reset();
    chk("idle_no_req", bif.imem_req, 1'b0);
    bif.run = 1'b1;
    pc_m = 32'd0;
    for (int i = 0; i < 9; i++) begin
      do_instr(tbl[i].reqn, tbl[i].multi, tbl[i].exen, tbl[i].br, tbl[i].tgt, tbl[i].rd,
               1'b0, 1'b0, tbl[i].exp_cyc, pc_m, tbl[i].exp_pc, 32'(i + 1),
               $sformatf("vec%0d", i));
      pc_m = tbl[i].exp_pc;
    end

    // Halt requested during DECODE: the instruction still retires, then the core parks.
    do_instr(1, 0, 1, 0, 32'h0, 5'd6, 1'b1, 1'b0, 4, 32'h0, 32'h1, 32'd10, "halt");
    chk("halt_state", bif.state, 3'd5);
    chk("halt_flag", {bif.halted, bif.fault}, 2'b10);
    for (int i = 0; i < 3; i++) step();
    chk("halt_sticky", bif.state, 3'd5);
    chk("halt_no_req", bif.imem_req, 1'b0);
    chk("halt_pc", bif.pc, 32'h1);

    // Reset while the executer is busy.
    do_reset();
    bif.run = 1'b1;
    do_instr(1, 0, 1, 0, 32'h0, 5'd3, 1'b0, 1'b0, 5, 32'h0, 32'h1, 32'd1, "pre_rst");
    bif.exec_multi = 1'b1;
    n = 0;
    while (bif.state != 3'd3 && n < 20) begin
      bif.imem_ack = bif.imem_req;
      step();
      n++;
    end
    bif.imem_ack = 1'b0;
    chk("mid_exec_reached", bif.state, 3'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_strobes", {bif.imem_req, bif.fetch_latch, bif.decode_latch, bif.exec_start, bif.rf_we}, 5'd0);
    chk("mid_rst_retire", bif.retire_cnt, 32'd0);
    chk("mid_rst_state", bif.state, 3'd0);
    chk("mid_rst_pc", bif.pc, 32'd0);
    rst = 1'b0;

    // Fetch watchdog: no ack ever arrives.
    do_reset();
    bif.run = 1'b1;
    nreq = 0; fcyc = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bif.fault && fcyc < 0) fcyc = nreq + 1;
      if (bif.imem_req) nreq++;
      step();
    end
    chk("wdog_req_cycles", nreq, 15);
    chk("wdog_fault_cycle", fcyc, 16);
    chk("wdog_state", bif.state, 3'd6);
    bif.imem_ack = 1'b1;
    #1;
    chk("wdog_flags", {bif.halted, bif.fault}, 2'b01);
    chk("wdog_no_strobes", {bif.imem_req, bif.fetch_latch}, 2'b00);
    step();
    do_reset();
    chk("wdog_exit_state", bif.state, 3'd0);

    // Random instruction stream against a transaction-level model.
    bif.run = 1'b1;
    pc_m = 32'd0; ret_m = 0; from_idle = 1;
    for (int i = 0; i < 40; i++) begin
      reqn  = $urandom_range(1, 6);
      multi = 1'($urandom_range(0, 1));
      exen  = $urandom_range(1, 5);
      br    = ($urandom_range(0, 3) == 0);
      tgt   = $urandom;
      rd    = 5'($urandom_range(0, 31));
      drop  = ($urandom_range(0, 5) == 0);
      exp_cyc = (from_idle ? 1 : 0) + reqn + 1 + (multi ? exen : 1) + 1;
      pc_n  = br ? tgt : pc_m + 32'd1;
      ret_m++;
      do_instr(reqn, multi, exen, br, tgt, rd, 1'b0, drop, exp_cyc, pc_m, pc_n, 32'(ret_m),
               $sformatf("rnd%0d", i));
      pc_m = pc_n;
      if (drop) begin
        chk($sformatf("rnd%0d_idle_after_stop", i), bif.state, 3'd0);
        bif.run = 1'b1;
        from_idle = 1;
      end else begin
        from_idle = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
